vta_mem_responder: RTL and testbench
====================================

VTA_MEM_RESPONDER -- requirements
Module: vta_mem_responder

Interface
REQ-001 SHALL have parameter LEN_BITS, default 8, beat-count field width (beats = len+1).
REQ-002 SHALL have parameter ADDR_BITS, default 64, byte address width.
REQ-003 SHALL have parameter DATA_BITS, default 64, beat width; power of two, >= 8.
REQ-004 SHALL have parameter MEM_WORDS_LOG2, default 10, log2 of array depth in DATA_BITS words.
REQ-005 SHALL have port clock, in, 1, the only clock.
REQ-006 SHALL have port reset, in, 1, synchronous, active-low (0 = reset).
REQ-007 SHALL have port dpi_req_valid, in, 1, request strobe, single cycle.
REQ-008 SHALL have port dpi_req_opcode, in, 1, 0 = read, 1 = write.
REQ-009 SHALL have port dpi_req_len, in, LEN_BITS, beats minus one.
REQ-010 SHALL have port dpi_req_addr, in, ADDR_BITS, byte start address.
REQ-011 SHALL have port dpi_wr_valid, in, 1, write beat strobe.
REQ-012 SHALL have port dpi_wr_bits, in, DATA_BITS, write beat data.
REQ-013 SHALL have port dpi_rd_valid, out, 1, read beat valid.
REQ-014 SHALL have port dpi_rd_bits, out, DATA_BITS, read beat data.
REQ-015 SHALL have port dpi_rd_ready, in, 1, read beat accept.
REQ-016 SHALL have port busy, out, 1, high whenever the FSM is not IDLE.
REQ-017 SHALL have port err, out, 1, sticky protocol-violation flag.

Function
REQ-018 SHALL implement FSM states IDLE, READ and WRITE.
REQ-019 In IDLE, dpi_req_valid=1 SHALL latch the word pointer (addr >> log2(DATA_BITS/8), low MEM_WORDS_LOG2 bits) and the remaining count (= len); next state SHALL be READ if opcode=0, WRITE if opcode=1.
REQ-020 Address byte-offset bits SHALL be ignored; upper word bits SHALL alias.
REQ-021 In READ, dpi_rd_valid SHALL be high from the cycle after acceptance, with dpi_rd_bits = mem[ptr], held stable until dpi_rd_valid & dpi_rd_ready.
REQ-022 On each read handshake: count=0 -> IDLE next cycle, dpi_rd_valid low; else ptr+1, count-1; with ready held high, one beat per cycle.
REQ-023 In WRITE, each cycle with dpi_wr_valid=1 SHALL write dpi_wr_bits to mem[ptr]; the beat with count=0 returns the FSM to IDLE; other beats increment ptr and decrement count.
REQ-024 ptr SHALL wrap modulo 2^MEM_WORDS_LOG2.
REQ-025 dpi_req_valid while busy, or dpi_wr_valid outside WRITE, SHALL be dropped and SHALL set err; the current burst SHALL be unaffected.
REQ-026 dpi_wr_valid in the same cycle the write request is accepted SHALL be an error (the first beat is legal from the next cycle).
REQ-027 Back-to-back requests SHALL be accepted: a new dpi_req_valid is legal in the first IDLE cycle.

Reset
REQ-028 reset=0 at a clock edge SHALL force IDLE, dpi_rd_valid=0, dpi_rd_bits=0, busy=0, err=0, ptr=0, count=0.
REQ-029 Memory array contents SHALL NOT be cleared by reset; reset mid-burst SHALL abandon the burst.

Configuration
REQ-030 With VTA_MEM_RESP_STALL_EN defined, parameter STALL_PERIOD (default 4) SHALL apply: after every STALL_PERIOD read handshakes within a burst, dpi_rd_valid SHALL be low for exactly one cycle; data is unaffected.
REQ-031 Without VTA_MEM_RESP_STALL_EN, no bubbles SHALL be inserted and STALL_PERIOD SHALL be absent.

Structure
REQ-032 Package vta_mem_pkg SHALL hold OP_RD=1'b0, OP_WR=1'b1, the state enum, and default width constants.
REQ-033 Storage SHALL be sub-module vta_mem_array: one synchronous write port, one asynchronous read port, depth 2^MEM_WORDS_LOG2.

Verification
REQ-034 Write addr 0x40, len 3, data 1..4, then read addr 0x40, len 3, ready=1 -> rd beats 1,2,3,4 on consecutive cycles, first beat 1 cycle after request.
REQ-035 Read len 1 with ready low for 3 cycles -> rd_valid high, rd_bits stable for 3 cycles, then 2 beats, then busy=0.
REQ-036 Write at word 1023, len 1 (depth 1024) -> words 1023 and 0 written; readback matches.
REQ-037 Request during active read -> err=1, original burst completes intact; err cleared only by reset.
REQ-038 Reset=0 mid write burst -> IDLE next cycle, busy=0, already-written words retained.
REQ-039 STALL_EN, read len 7, ready=1 -> one rd_valid bubble after beat 4, 8 beats total in 9 cycles.

Source files
------------

// File: rtl/vta_mem_pkg.sv
// Shared constants and state type for the VTA memory responder.
package vta_mem_pkg;

  localparam int unsigned LEN_BITS_DEF       = 8;
  localparam int unsigned ADDR_BITS_DEF      = 64;
  localparam int unsigned DATA_BITS_DEF      = 64;
  localparam int unsigned MEM_WORDS_LOG2_DEF = 10;
  localparam int unsigned STALL_PERIOD_DEF   = 4;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/vta_mem_array.sv
// Word-addressed storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module vta_mem_array
  import vta_mem_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned ADDR_W    = MEM_WORDS_LOG2_DEF
) (
  input  logic                 clock,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vta_mem_responder.sv
// VTA DPI-style memory responder: serves read/write bursts from a local array.
// Optional feature macro: VTA_MEM_RESP_STALL_EN inserts a one-cycle read
// bubble after every STALL_PERIOD handshakes within a burst.
module vta_mem_responder
  import vta_mem_pkg::*;
#(
  parameter int unsigned LEN_BITS       = LEN_BITS_DEF,
  parameter int unsigned ADDR_BITS      = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS      = DATA_BITS_DEF,
  parameter int unsigned MEM_WORDS_LOG2 = MEM_WORDS_LOG2_DEF
`ifdef VTA_MEM_RESP_STALL_EN
  ,
  parameter int unsigned STALL_PERIOD   = STALL_PERIOD_DEF
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dpi_req_valid,
  input  logic                 dpi_req_opcode,
  input  logic [LEN_BITS-1:0]  dpi_req_len,
  input  logic [ADDR_BITS-1:0] dpi_req_addr,
  input  logic                 dpi_wr_valid,
  input  logic [DATA_BITS-1:0] dpi_wr_bits,
  output logic                 dpi_rd_valid,
  output logic [DATA_BITS-1:0] dpi_rd_bits,
  input  logic                 dpi_rd_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned OFF_BITS = $clog2(DATA_BITS / 8);
  localparam int unsigned PTR_W    = MEM_WORDS_LOG2;
`ifdef VTA_MEM_RESP_STALL_EN
  localparam int unsigned HS_W     = $clog2(STALL_PERIOD + 1);
`endif

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [LEN_BITS-1:0]  cnt_q, cnt_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_BITS-1:0] rd_bits_q, rd_bits_d;
  logic                 busy_q;
  logic                 err_q, err_d;
`ifdef VTA_MEM_RESP_STALL_EN
  logic [HS_W-1:0]      hs_q, hs_d;
`endif

  logic [PTR_W-1:0]     req_ptr_c;
  logic [PTR_W-1:0]     raddr_c;
  logic [DATA_BITS-1:0] rdata_c;
  logic                 we_c;
  logic                 rd_hs_c;
  logic                 unused_addr;

  // Byte-offset bits dropped, upper word bits alias into the array.
  assign req_ptr_c   = dpi_req_addr[OFF_BITS +: PTR_W];
  assign unused_addr = ^dpi_req_addr;

  // Look up the first beat on acceptance, otherwise prefetch the next beat.
  assign raddr_c = (state_q == IDLE) ? req_ptr_c : ptr_q + PTR_W'(1);
  assign we_c    = (state_q == WRITE) && dpi_wr_valid;
  assign rd_hs_c = rd_valid_q && dpi_rd_ready;

  vta_mem_array #(
    .DATA_BITS (DATA_BITS),
    .ADDR_W    (PTR_W)
  ) u_mem (
    .clock   (clock),
    .we_i    (we_c),
    .waddr_i (ptr_q),
    .wdata_i (dpi_wr_bits),
    .raddr_i (raddr_c),
    .rdata_o (rdata_c)
  );

  // Next-state, pointer/count and read-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    rd_bits_d  = rd_bits_q;
    err_d      = err_q;
`ifdef VTA_MEM_RESP_STALL_EN
    hs_d       = hs_q;
`endif

    if (dpi_wr_valid && (state_q != WRITE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (dpi_req_valid) begin
          ptr_d = req_ptr_c;
          cnt_d = dpi_req_len;
`ifdef VTA_MEM_RESP_STALL_EN
          hs_d  = '0;
`endif
          if (dpi_req_opcode == OP_RD) begin
            state_d    = READ;
            rd_valid_d = 1'b1;
            rd_bits_d  = rdata_c;
          end else begin
            state_d = WRITE;
          end
        end
      end

      READ: begin
        if (dpi_req_valid) begin
          err_d = 1'b1;
        end
`ifdef VTA_MEM_RESP_STALL_EN
        if (!rd_valid_q) begin
          rd_valid_d = 1'b1;
        end
`endif
        if (rd_hs_c) begin
          if (cnt_q == '0) begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
          end else begin
            ptr_d     = ptr_q + PTR_W'(1);
            cnt_d     = cnt_q - LEN_BITS'(1);
            rd_bits_d = rdata_c;
`ifdef VTA_MEM_RESP_STALL_EN
            if (hs_q == HS_W'(STALL_PERIOD - 1)) begin
              hs_d       = '0;
              rd_valid_d = 1'b0;
            end else begin
              hs_d = hs_q + HS_W'(1);
            end
`endif
          end
        end
      end

      WRITE: begin
        if (dpi_req_valid) begin
          err_d = 1'b1;
        end
        if (dpi_wr_valid) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
            cnt_d = cnt_q - LEN_BITS'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_bits_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef VTA_MEM_RESP_STALL_EN
      hs_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_bits_q  <= rd_bits_d;
      busy_q     <= (state_d != IDLE);
      err_q      <= err_d;
`ifdef VTA_MEM_RESP_STALL_EN
      hs_q       <= hs_d;
`endif
    end
  end

  assign dpi_rd_valid = rd_valid_q;
  assign dpi_rd_bits  = rd_bits_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_vta_mem_responder.sv
// Randomized bench for vta_mem_responder against a word-array reference model.
// Honours VTA_MEM_RESP_STALL_EN when defined.
module tb_vta_mem_responder;

  localparam int DEPTH = 1024;
`ifdef VTA_MEM_RESP_STALL_EN
  localparam int SP = 4;
`endif

  logic        clock;
  logic        reset;
  logic        dpi_req_valid;
  logic        dpi_req_opcode;
  logic [7:0]  dpi_req_len;
  logic [63:0] dpi_req_addr;
  logic        dpi_wr_valid;
  logic [63:0] dpi_wr_bits;
  logic        dpi_rd_valid;
  logic [63:0] dpi_rd_bits;
  logic        dpi_rd_ready;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_err = 0;
  logic [63:0] mem_m [DEPTH];

  vta_mem_responder #(
    .LEN_BITS       (8),
    .ADDR_BITS      (64),
    .DATA_BITS      (64),
    .MEM_WORDS_LOG2 (10)
`ifdef VTA_MEM_RESP_STALL_EN
    ,
    .STALL_PERIOD   (SP)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dpi_req_valid  (dpi_req_valid),
    .dpi_req_opcode (dpi_req_opcode),
    .dpi_req_len    (dpi_req_len),
    .dpi_req_addr   (dpi_req_addr),
    .dpi_wr_valid   (dpi_wr_valid),
    .dpi_wr_bits    (dpi_wr_bits),
    .dpi_rd_valid   (dpi_rd_valid),
    .dpi_rd_bits    (dpi_rd_bits),
    .dpi_rd_ready   (dpi_rd_ready),
    .busy           (busy),
    .err            (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [63:0] a);
    return int'((a >> 3) & 64'd1023);
  endfunction

  // Write burst; called and returns at a negedge in the first idle cycle.
  task automatic wr_burst(input logic [63:0] addr, input int len, input int gap_pct,
                          input bit seq, input int abort_at, input bit early);
    int w;
    logic [63:0] data;
    w = word_of(addr);
    dpi_req_valid  = 1'b1;
    dpi_req_opcode = 1'b1;
    dpi_req_len    = 8'(len);
    dpi_req_addr   = addr;
    if (early) begin
      dpi_wr_valid = 1'b1;
      dpi_wr_bits  = {$urandom, $urandom};
      exp_err      = 1'b1;
    end
    @(negedge clock);
    dpi_req_valid = 1'b0;
    dpi_wr_valid  = 1'b0;
    for (int i = 0; i <= len; i++) begin
      dpi_wr_valid = 1'b0;
      if (i == abort_at) begin
        reset = 1'b0;
        @(negedge clock);
        reset   = 1'b1;
        exp_err = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_rd_valid", 64'(dpi_rd_valid), 64'(0));
        check("abort_rd_bits", dpi_rd_bits, 64'(0));
        check("abort_err", 64'(err), 64'(0));
        return;
      end
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        check("wr_gap_busy", 64'(busy), 64'(1));
        @(negedge clock);
      end
      check("wr_busy", 64'(busy), 64'(1));
      data = seq ? 64'(i + 1) : {$urandom, $urandom};
      dpi_wr_valid = 1'b1;
      dpi_wr_bits  = data;
      mem_m[(w + i) % DEPTH] = data;
      @(negedge clock);
    end
    dpi_wr_valid = 1'b0;
    check("wr_done_busy", 64'(busy), 64'(0));
    check("wr_err", 64'(err), 64'(exp_err));
  endtask

  // Read burst; mode 0 random ready, 1 ready always, 2 ready low for 3 cycles.
  task automatic rd_burst(input logic [63:0] addr, input int len, input int mode, input bit inject);
    int w, k, cyc, bubbles;
    bit bub, rdy, exp_v;
    w = word_of(addr);
    dpi_req_valid  = 1'b1;
    dpi_req_opcode = 1'b0;
    dpi_req_len    = 8'(len);
    dpi_req_addr   = addr;
    @(negedge clock);
    dpi_req_valid = 1'b0;
    k = 0; cyc = 0; bub = 1'b0;
    while (k <= len && cyc < 2000) begin
      exp_v = !bub;
      check("rd_valid", 64'(dpi_rd_valid), 64'(exp_v));
      check("rd_busy", 64'(busy), 64'(1));
      if (exp_v) check("rd_bits", dpi_rd_bits, mem_m[(w + k) % DEPTH]);
      case (mode)
        0:       rdy = ($urandom_range(99) < 70);
        1:       rdy = 1'b1;
        default: rdy = (cyc >= 3);
      endcase
      dpi_rd_ready = rdy;
      if (inject && cyc == 0) begin
        dpi_req_valid  = 1'b1;
        dpi_req_opcode = 1'($urandom_range(1));
        dpi_req_addr   = {$urandom, $urandom};
        dpi_wr_valid   = 1'b1;
        dpi_wr_bits    = {$urandom, $urandom};
        exp_err        = 1'b1;
      end
      @(negedge clock);
      dpi_req_valid = 1'b0;
      dpi_wr_valid  = 1'b0;
      bub = 1'b0;
      if (exp_v && rdy) begin
        k++;
`ifdef VTA_MEM_RESP_STALL_EN
        if ((k % SP) == 0 && k <= len) bub = 1'b1;
`endif
      end
      cyc++;
    end
    if (k <= len) check("rd_timeout_beats", 64'(k), 64'(len + 1));
`ifdef VTA_MEM_RESP_STALL_EN
    bubbles = len / SP;
`else
    bubbles = 0;
`endif
    if (mode == 1) check("rd_cycles", 64'(cyc), 64'(len + 1 + bubbles));
    dpi_rd_ready = 1'b0;
    check("rd_done_valid", 64'(dpi_rd_valid), 64'(0));
    check("rd_done_busy", 64'(busy), 64'(0));
    check("rd_err", 64'(err), 64'(exp_err));
  endtask

  initial begin
    reset          = 1'b0;
    dpi_req_valid  = 1'b0;
    dpi_req_opcode = 1'b0;
    dpi_req_len    = '0;
    dpi_req_addr   = '0;
    dpi_wr_valid   = 1'b0;
    dpi_wr_bits    = '0;
    dpi_rd_ready   = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_rd_valid", 64'(dpi_rd_valid), 64'(0));
    check("rst_rd_bits", dpi_rd_bits, 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    reset = 1'b1;
    @(negedge clock);

    // Fill the whole array so any address has a known expected value.
    for (int b = 0; b < 4; b++) wr_burst(64'(b * 256 * 8), 255, 0, 1'b0, -1, 1'b0);

    // Sequential data 1..4 at 0x40, read back with ready held high.
    wr_burst(64'h40, 3, 0, 1'b1, -1, 1'b0);
    rd_burst(64'h40, 3, 1, 1'b0);

    // Ready held low for three cycles: data must stay put.
    rd_burst(64'h40, 1, 2, 1'b0);

    // Wrap from the last word to word 0, plus an aliased, misaligned address.
    wr_burst(64'(1023 * 8), 1, 20, 1'b0, -1, 1'b0);
    rd_burst(64'(1023 * 8), 1, 1, 1'b0);
    rd_burst(64'h0, 0, 1, 1'b0);
    rd_burst(64'hABC0_0000_0000_1FFD, 1, 0, 1'b0);

    // Violations during a read are dropped and make err sticky.
    rd_burst(64'h40, 3, 1, 1'b1);
    rd_burst(64'h48, 0, 1, 1'b0);

    // Reset mid write burst keeps the beats already written.
    wr_burst(64'h800, 7, 0, 1'b0, -1, 1'b0);
    wr_burst(64'h800, 7, 0, 1'b0, 3, 1'b0);
    rd_burst(64'h800, 7, 1, 1'b0);

    // Beat in the same cycle as write acceptance is an error and dropped.
    wr_burst(64'h200, 2, 0, 1'b0, -1, 1'b1);
    rd_burst(64'h200, 2, 0, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    reset   = 1'b1;
    exp_err = 1'b0;
    check("err_cleared", 64'(err), 64'(0));

    // Random back-to-back traffic.
    for (int n = 0; n < 24; n++) begin
      logic [63:0] a;
      int l;
      a = {$urandom, $urandom};
      l = $urandom_range(15);
      if ($urandom_range(1) == 1) wr_burst(a, l, 30, 1'b0, -1, 1'b0);
      else rd_burst(a, l, 0, ($urandom_range(5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
